// File: rtl/msg_checker_pkg.sv
// Shared types and constants for the msg_checker plaintext acceptance stage.
package msg_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } msg_chk_state_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_LO_A  = 8'h61;
  localparam logic [7:0] CHAR_LO_Z  = 8'h7A;

  localparam int unsigned MSG_LEN_DEFAULT = 32;

endpackage

// File: rtl/msg_char_class.sv
// Plaintext alphabet classifier: lowercase a-z or space is legal.
module msg_char_class
  import msg_checker_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_legal
);

  assign is_legal = (char_in == CHAR_SPACE) ||
                    ((char_in >= CHAR_LO_A) && (char_in <= CHAR_LO_Z));

endmodule

// File: rtl/msg_checker.sv
// Plaintext acceptance stage: rejects a candidate key on the first illegal byte.
// Define MSG_CHECKER_CAPTURE_EN to build the bad_index/bad_byte capture registers.
module msg_checker
  import msg_checker_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             busy,
  output logic             abort,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] bytes_ok,
  output logic [CNT_W-1:0] bad_index,
  output logic [7:0]       bad_byte
);

  msg_chk_state_t state;
  logic           is_legal;

  msg_char_class u_char_class (
    .char_in  (byte_data),
    .is_legal (is_legal)
  );

  // start has priority over any byte in every state, so a byte strobed
  // in the same cycle is dropped and the counter restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      abort    <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      bytes_ok <= '0;
    end else begin
      abort <= 1'b0;
      if (start) begin
        state    <= CHECK;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
        bytes_ok <= '0;
      end else begin
        case (state)
          CHECK: begin
            if (byte_valid) begin
              if (!is_legal) begin
                abort <= 1'b1;
                pass  <= 1'b0;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else if (bytes_ok == CNT_W'(MSG_LEN - 1)) begin
                bytes_ok <= CNT_W'(MSG_LEN);
                pass     <= 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= DONE;
              end else begin
                bytes_ok <= bytes_ok + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MSG_CHECKER_CAPTURE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bad_index <= '0;
      bad_byte  <= '0;
    end else if (start) begin
      bad_index <= '0;
      bad_byte  <= '0;
    end else if ((state == CHECK) && byte_valid && !is_legal) begin
      bad_index <= bytes_ok;
      bad_byte  <= byte_data;
    end
  end
`else
  assign bad_index = '0;
  assign bad_byte  = '0;
`endif

endmodule

// File: doc/msg_checker.md
# msg_checker

Plaintext acceptance stage for the RC4 key-search datapath. Sits directly downstream of the RC4 decryption core and observes each decrypted byte as the core writes it into decrypted-message memory. It rejects a candidate key on the first byte outside the legal plaintext alphabet, which is lowercase a–z and space. It pulses `abort` so the core and key-search FSM can move to the next key without finishing the message. It also reports a registered pass/fail verdict, which drives the success/fail LEDs.

## Interface
- `MSG_LEN`, 32: number of plaintext bytes per message; legal range 2..255.
- `CNT_W`, 8: width of the byte counter; must satisfy 2^CNT_W > MSG_LEN.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begin checking a new candidate key.
- `byte_valid`  in  1  strobe; `byte_data` is a decrypted byte this cycle.
- `byte_data`  in  8  decrypted byte, in message order.
- `busy`  out  1  high while in CHECK.
- `abort`  out  1  single-cycle pulse on the first illegal byte.
- `done`  out  1  level; verdict valid; held until next `start`.
- `pass`  out  1  verdict; meaningful only while `done`=1.
- `bytes_ok`  out  CNT_W  count of legal bytes accepted for the current candidate.
- `bad_index`  out  CNT_W  index of the first illegal byte (capture feature).
- `bad_byte`  out  8  value of the first illegal byte (capture feature).

## Operation
- States are IDLE, CHECK and DONE. All outputs are registered.
- Legal byte: `byte_data` == 8'h20, or 8'h61 ≤ `byte_data` ≤ 8'h7A.
- **IDLE**
  - `start` → CHECK, clear `bytes_ok`, clear `done` and `pass`.
  - `byte_valid` is ignored.
- **CHECK**, on `byte_valid`:
  - Illegal byte → `abort`=1 for one cycle, `pass`=0, `done`=1, go to DONE.
  - Legal byte and `bytes_ok` == MSG_LEN-1 → `bytes_ok`=MSG_LEN, `pass`=1, `done`=1, go to DONE.
  - Legal byte otherwise → `bytes_ok`++.
- **DONE**
  - Holds the verdict.
  - `start` → CHECK, as in IDLE.
  - `byte_valid` is ignored. The upstream core may still flush bytes after `abort`.
- Simultaneous `start` and `byte_valid` in any state: `start` wins, the counter clears, and that byte is dropped. Upstream never strobes a byte in its own start cycle.
- `start` mid-CHECK restarts cleanly: counter cleared, no `abort`, no verdict.
- The counter never wraps: it saturates at MSG_LEN because CHECK exits there.
- `reset_n` low at any time:
  - Immediately forces IDLE.
  - All outputs go to 0: `busy`, `abort`, `done`, `pass`, `bytes_ok`, `bad_index`, `bad_byte`.
  - An in-flight check is discarded.

## Timing
- Verdict latency is 1 cycle. `done`, `pass` and `abort` assert on the edge after the cycle in which the deciding `byte_valid` is sampled.
- `busy` rises 1 cycle after `start` and falls together with the rise of `done`.
- `abort` is high for exactly one cycle per candidate, and never when `pass`=1.
- Throughput: one byte per cycle, with back-to-back `byte_valid` supported.
- `start` may be issued the cycle after `done` rises. A minimum candidate turnaround of 2 cycles is allowed.

## Configuration
- `MSG_CHECKER_CAPTURE_EN` defined:
  - On the illegal byte, `bad_index` ← current `bytes_ok` and `bad_byte` ← `byte_data`.
  - Both hold until the next `start`, which clears them to 0.
  - Both feed the HEX debug display.
- `MSG_CHECKER_CAPTURE_EN` not defined:
  - `bad_index` and `bad_byte` are tied to 0 and no capture registers are built.
  - All other behaviour is identical.

## Structure
- Shared package `msg_checker_pkg` holds:
  - The state enum `msg_chk_state_t` (IDLE, CHECK, DONE).
  - `CHAR_SPACE`=8'h20, `CHAR_LO_A`=8'h61, `CHAR_LO_Z`=8'h7A.
  - Default `MSG_LEN`.
- One sub-module, `msg_char_class`: purely combinational, 8-bit in → `is_legal` out. It is reused by the key-search FSM for its own statistics.

## Test plan
- Reset mid-CHECK after 10 legal bytes → all outputs 0 in the same cycle and state IDLE; a subsequent `start` with 32 legal bytes → `pass`=1.
- `start`, then 32 bytes "attack at dawn..." (all within a–z or space), back-to-back → `done`=1 and `pass`=1 one cycle after byte 31, `bytes_ok`=32, `abort` never asserted.
- `start`, 5 legal bytes, then 8'h41 ('A') → `abort` pulses once, `done`=1, `pass`=0, `bytes_ok`=5. With capture on: `bad_index`=5, `bad_byte`=8'h41.
- Boundary characters 8'h20, 8'h61, 8'h7A are accepted; 8'h1F, 8'h60, 8'h7B each trigger `abort` as the first byte, with `bytes_ok`=0.
- After `abort`, 20 further `byte_valid` strobes → no output changes; `start` plus `byte_valid` in the same cycle → byte dropped, `bytes_ok`=0, `busy`=1 on the next cycle.
- `start` at byte 12 of CHECK → no `abort`, counter restarts; the next 32 legal bytes → `pass`=1.
